// File: rtl/cfg_chain_loader_if.sv
// Host-side configuration word bus: one word per valid/ready handshake.
interface cfg_chain_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] cfg_word;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (
    output cfg_word,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_word,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/cfg_chain_loader.sv
// Serializes host config words LSB-first onto a slice shift chain,
// then fires a one-cycle set pulse so every slice latches its bits.
module cfg_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  cfg_chain_loader_if.slave cfg,
  output logic cen,
  output logic shift_out,
  output logic set_out,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int NW = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WORD,
    SHIFT,
    SET,
    DONE
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     sent;
  logic [NW-1:0]     wcnt;
  logic              ready_q;
  logic [CW-1:0]     remain;
  logic [NW-1:0]     nbits;
  logic              take;
  logic              last;
  logic              fin;

  // abort wins over the handshake in the same cycle
  assign cfg.cfg_ready = ready_q & ~abort;
  assign take   = cfg.cfg_valid & cfg.cfg_ready;
  assign remain = CW'(CHAIN_LEN) - sent;
  assign last   = (wcnt == NW'(1));
  assign fin    = ((sent + CW'(1)) == CW'(CHAIN_LEN));

  // the final word only carries what is left of the chain
  always_comb begin
    nbits = NW'(WORD_W);
    if (int'(remain) < WORD_W)
      nbits = NW'(remain);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      sent      <= '0;
      wcnt      <= '0;
      ready_q   <= 1'b0;
      cen       <= 1'b0;
      shift_out <= 1'b0;
      set_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      set_out <= 1'b0;
      done    <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        shreg     <= '0;
        wcnt      <= '0;
        ready_q   <= 1'b0;
        cen       <= 1'b0;
        shift_out <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state   <= WAIT_WORD;
              sent    <= '0;
              ready_q <= 1'b1;
              busy    <= 1'b1;
            end
          end
          WAIT_WORD: begin
            if (take) begin
              state     <= SHIFT;
              ready_q   <= 1'b0;
              cen       <= 1'b1;
              shift_out <= cfg.cfg_word[0];
              shreg     <= cfg.cfg_word >> 1;
              wcnt      <= nbits;
            end
          end
          SHIFT: begin
            sent <= sent + CW'(1);
            wcnt <= wcnt - NW'(1);
            if (last) begin
              cen       <= 1'b0;
              shift_out <= 1'b0;
              if (fin) begin
                state   <= SET;
                set_out <= 1'b1;
              end else begin
                state   <= WAIT_WORD;
                ready_q <= 1'b1;
              end
            end else begin
              shift_out <= shreg[0];
              shreg     <= shreg >> 1;
            end
          end
          SET: begin
            state <= DONE;
            done  <= 1'b1;
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: three instances (200/32, 64/32, 1/32)
// with a per-instance serial-bit scoreboard.
module tb_cfg_chain_loader;

  logic        clk;
  logic        rst;
  logic        start_s [3];
  logic        abort_s [3];
  logic        vld [3];
  logic [31:0] wrd [3];
  wire         rdy [3];
  wire         cen [3];
  wire         sout [3];
  wire         setv [3];
  wire         busy [3];
  wire         done [3];

  int compared;
  int mismatched;
  int cyc;
  int hs [3];
  int cenc [3];
  int setc [3];
  int donec [3];
  int busyc [3];
  int last_cen [3];
  int set_cyc [3];
  int done_cyc [3];
  int st_cyc [3];

  bit exp0 [$];
  bit exp1 [$];
  bit exp2 [$];

  cfg_chain_loader_if #(.WORD_W(32)) ifa ();
  cfg_chain_loader_if #(.WORD_W(32)) ifb ();
  cfg_chain_loader_if #(.WORD_W(32)) ifc ();

  assign ifa.cfg_word  = wrd[0];
  assign ifa.cfg_valid = vld[0];
  assign rdy[0]        = ifa.cfg_ready;
  assign ifb.cfg_word  = wrd[1];
  assign ifb.cfg_valid = vld[1];
  assign rdy[1]        = ifb.cfg_ready;
  assign ifc.cfg_word  = wrd[2];
  assign ifc.cfg_valid = vld[2];
  assign rdy[2]        = ifc.cfg_ready;

  cfg_chain_loader #(.WORD_W(32), .CHAIN_LEN(200)) u_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]),
    .cfg(ifa), .cen(cen[0]), .shift_out(sout[0]),
    .set_out(setv[0]), .busy(busy[0]), .done(done[0])
  );

  cfg_chain_loader #(.WORD_W(32), .CHAIN_LEN(64)) u_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]),
    .cfg(ifb), .cen(cen[1]), .shift_out(sout[1]),
    .set_out(setv[1]), .busy(busy[1]), .done(done[1])
  );

  cfg_chain_loader #(.WORD_W(32), .CHAIN_LEN(1)) u_c (
    .clk(clk), .rst(rst), .start(start_s[2]), .abort(abort_s[2]),
    .cfg(ifc), .cen(cen[2]), .shift_out(sout[2]),
    .set_out(setv[2]), .busy(busy[2]), .done(done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int q_size(input int d);
    case (d)
      0: return exp0.size();
      1: return exp1.size();
      default: return exp2.size();
    endcase
  endfunction

  function automatic bit q_pop(input int d);
    case (d)
      0: return exp0.pop_front();
      1: return exp1.pop_front();
      default: return exp2.pop_front();
    endcase
  endfunction

  task automatic q_push(input int d, input bit b);
    case (d)
      0: exp0.push_back(b);
      1: exp1.push_back(b);
      default: exp2.push_back(b);
    endcase
  endtask

  task automatic q_flush(input int d);
    case (d)
      0: exp0.delete();
      1: exp1.delete();
      default: exp2.delete();
    endcase
  endtask

  // scoreboard: every cen cycle pops one expected chain bit
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (vld[d] && rdy[d]) hs[d]++;
      if (busy[d]) busyc[d]++;
      if (setv[d]) begin setc[d]++; set_cyc[d] = cyc; end
      if (done[d]) begin donec[d]++; done_cyc[d] = cyc; end
      if (cen[d]) begin
        cenc[d]++;
        last_cen[d] = cyc;
        compared++;
        if (q_size(d) == 0) begin
          mismatched++;
          $display("FAIL extra_bit dut%0d cyc %0d: cen=1 want no bit",
                   d, cyc);
        end else begin
          bit b;
          b = q_pop(d);
          if (sout[d] !== b) begin
            mismatched++;
            $display("FAIL stream dut%0d cyc %0d: got %b want %b",
                     d, cyc, sout[d], b);
          end
        end
      end else begin
        compared++;
        if (sout[d] !== 1'b0) begin
          mismatched++;
          $display("FAIL idle_sout dut%0d cyc %0d: got %b want 0",
                   d, cyc, sout[d]);
        end
      end
    end
  end

  task automatic clr(input int d);
    hs[d] = 0; cenc[d] = 0; setc[d] = 0; donec[d] = 0;
    busyc[d] = 0; last_cen[d] = -1; set_cyc[d] = -1;
    done_cyc[d] = -1;
  endtask

  task automatic pulse_start(input int d);
    start_s[d] = 1'b1;
    st_cyc[d]  = cyc;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
  endtask

  // pushes the n bits the chain should see, then holds valid until taken
  task automatic send_word(input int d, input logic [31:0] w,
                           input int n, output bit ok);
    for (int i = 0; i < n; i++) q_push(d, w[i]);
    wrd[d] = w;
    vld[d] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      if (rdy[d]) ok = 1'b1;
      @(posedge clk); #1;
    end
    vld[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clk);
      if (done[d]) ok = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic int nb200(input int i);
    return (200 - 32 * i) < 32 ? (200 - 32 * i) : 32;
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      compared++;
      if ({cen[d], sout[d], setv[d], busy[d], done[d], rdy[d]}
          !== 6'b0) begin
        mismatched++;
        $display("FAIL reset_outs dut%0d: got %b want 000000", d,
          {cen[d], sout[d], setv[d], busy[d], done[d], rdy[d]});
      end
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_full_load(input string tag);
    bit ok;
    clr(0);
    pulse_start(0);
    compared++;
    if (rdy[0] !== 1'b1 || busy[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_ready_t1: got rdy=%b busy=%b want 1 1",
               tag, rdy[0], busy[0]);
    end
    for (int i = 0; i < 7; i++) begin
      send_word(0, 32'(i + 1), nb200(i), ok);
      compared++;
      if (!ok || cen[0] !== 1'b1) begin
        mismatched++;
        $display("FAIL %s_accept w%0d: got ok=%b cen=%b want 1 1",
                 tag, i, ok, cen[0]);
      end
    end
    wait_done(0, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s_done_timeout: got none want done", tag);
    end
    compared++;
    if (hs[0] !== 7 || cenc[0] !== 200 || q_size(0) !== 0) begin
      mismatched++;
      $display("FAIL %s_counts: got hs=%0d cen=%0d left=%0d want 7 200 0",
               tag, hs[0], cenc[0], q_size(0));
    end
    compared++;
    if (setc[0] !== 1 || donec[0] !== 1) begin
      mismatched++;
      $display("FAIL %s_pulses: got set=%0d done=%0d want 1 1",
               tag, setc[0], donec[0]);
    end
    compared++;
    if (set_cyc[0] !== last_cen[0] + 1 || done_cyc[0] !== set_cyc[0] + 1)
    begin
      mismatched++;
      $display("FAIL %s_seq: got F=%0d set=%0d done=%0d want F+1 F+2",
               tag, last_cen[0], set_cyc[0], done_cyc[0]);
    end
    compared++;
    if (busyc[0] !== 209 || done_cyc[0] - st_cyc[0] + 1 !== 210) begin
      mismatched++;
      $display("FAIL %s_len: got busy=%0d load=%0d want 209 210",
               tag, busyc[0], done_cyc[0] - st_cyc[0] + 1);
    end
    compared++;
    if (busy[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_busy_end: got %b want 0", tag, busy[0]);
    end
  endtask

  task automatic test_host_stall;
    bit ok;
    bit seen;
    int bad;
    clr(0);
    pulse_start(0);
    send_word(0, 32'd1, 32, ok);
    // a start pulse mid-load must not disturb anything
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    send_word(0, 32'd2, 32, ok);
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (rdy[0]) seen = 1'b1;
    end
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (cen[0] !== 1'b0) bad++;
    end
    @(posedge clk); #1;
    compared++;
    if (!seen || bad !== 0) begin
      mismatched++;
      $display("FAIL stall_cen: got seen=%b cen_hi=%0d want 1 0",
               seen, bad);
    end
    for (int i = 2; i < 7; i++) send_word(0, 32'(i + 1), nb200(i), ok);
    wait_done(0, ok);
    compared++;
    if (hs[0] !== 7 || cenc[0] !== 200 || q_size(0) !== 0) begin
      mismatched++;
      $display("FAIL stall_counts: got hs=%0d cen=%0d left=%0d want 7 200 0",
               hs[0], cenc[0], q_size(0));
    end
    compared++;
    if (setc[0] !== 1 || donec[0] !== 1) begin
      mismatched++;
      $display("FAIL stall_pulses: got set=%0d done=%0d want 1 1",
               setc[0], donec[0]);
    end
  endtask

  task automatic test_abort;
    bit ok;
    clr(0);
    pulse_start(0);
    for (int i = 0; i < 4; i++) send_word(0, 32'(i + 1), 32, ok);
    repeat (4) @(posedge clk);
    #1;
    abort_s[0] = 1'b1;
    @(posedge clk); #1;
    abort_s[0] = 1'b0;
    compared++;
    if ({cen[0], busy[0], rdy[0]} !== 3'b000) begin
      mismatched++;
      $display("FAIL abort_idle: got cen/busy/rdy=%b want 000",
               {cen[0], busy[0], rdy[0]});
    end
    repeat (20) @(posedge clk);
    #1;
    compared++;
    if (cenc[0] !== 101 || q_size(0) !== 27) begin
      mismatched++;
      $display("FAIL abort_bits: got cen=%0d left=%0d want 101 27",
               cenc[0], q_size(0));
    end
    compared++;
    if (setc[0] !== 0 || donec[0] !== 0) begin
      mismatched++;
      $display("FAIL abort_pulses: got set=%0d done=%0d want 0 0",
               setc[0], donec[0]);
    end
    q_flush(0);
    pulse_start(0);
    wrd[0] = 32'hDEAD_BEEF;
    vld[0] = 1'b1;
    abort_s[0] = 1'b1;
    #1;
    compared++;
    if (rdy[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_ready: got %b want 0", rdy[0]);
    end
    @(posedge clk); #1;
    abort_s[0] = 1'b0;
    vld[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    compared++;
    if (hs[0] !== 4 || busy[0] !== 1'b0 || cenc[0] !== 101) begin
      mismatched++;
      $display("FAIL abort_wait: got hs=%0d busy=%b cen=%0d want 4 0 101",
               hs[0], busy[0], cenc[0]);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    clr(0);
    pulse_start(0);
    send_word(0, 32'd1, 32, ok);
    send_word(0, 32'd2, 32, ok);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    compared++;
    if ({cen[0], sout[0], setv[0], busy[0], done[0], rdy[0]} !== 6'b0)
    begin
      mismatched++;
      $display("FAIL rstmid_outs: got %b want 000000",
        {cen[0], sout[0], setv[0], busy[0], done[0], rdy[0]});
    end
    q_flush(0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    compared++;
    if (setc[0] !== 0 || donec[0] !== 0 || busy[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_after: got set=%0d done=%0d busy=%b want 0 0 0",
               setc[0], donec[0], busy[0]);
    end
  endtask

  task automatic test_exact_multiple;
    bit ok;
    clr(1);
    pulse_start(1);
    send_word(1, 32'hA5A5_A5A5, 32, ok);
    send_word(1, 32'hFFFF_0000, 32, ok);
    wrd[1] = 32'h1234_5678;
    vld[1] = 1'b1;
    wait_done(1, ok);
    repeat (5) @(posedge clk);
    #1;
    vld[1] = 1'b0;
    compared++;
    if (!ok || hs[1] !== 2 || cenc[1] !== 64 || q_size(1) !== 0) begin
      mismatched++;
      $display("FAIL exact_counts: got ok=%b hs=%0d cen=%0d left=%0d want 1 2 64 0",
               ok, hs[1], cenc[1], q_size(1));
    end
    compared++;
    if (setc[1] !== 1 || donec[1] !== 1 || done_cyc[1] !== set_cyc[1] + 1)
    begin
      mismatched++;
      $display("FAIL exact_pulses: got set=%0d done=%0d want 1 1 adjacent",
               setc[1], donec[1]);
    end
  endtask

  task automatic test_chain_len1;
    bit ok;
    clr(2);
    pulse_start(2);
    send_word(2, 32'hFFFF_FFFF, 1, ok);
    wait_done(2, ok);
    compared++;
    if (!ok || hs[2] !== 1 || cenc[2] !== 1 || q_size(2) !== 0) begin
      mismatched++;
      $display("FAIL len1_counts: got ok=%b hs=%0d cen=%0d left=%0d want 1 1 1 0",
               ok, hs[2], cenc[2], q_size(2));
    end
    compared++;
    if (set_cyc[2] !== last_cen[2] + 1 || done_cyc[2] !== set_cyc[2] + 1)
    begin
      mismatched++;
      $display("FAIL len1_seq: got F=%0d set=%0d done=%0d want F+1 F+2",
               last_cen[2], set_cyc[2], done_cyc[2]);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    rst        = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0;
      abort_s[d] = 1'b0;
      vld[d]     = 1'b0;
      wrd[d]     = '0;
      clr(d);
      st_cyc[d]  = 0;
    end
    test_reset;
    test_full_load("full");
    test_host_stall;
    test_abort;
    test_full_load("after_abort");
    test_reset_mid;
    test_full_load("after_reset");
    test_exact_multiple;
    test_chain_len1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
